// File: rtl/dct_row_sequencer_pkg.sv
// dct_row_sequencer_pkg: shared widths, FSM states and the Q16.16 8-point DCT-II basis table
package dct_row_sequencer_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int DATA_DEPTH = 8;
  localparam int ROW_WIDTH  = DATA_WIDTH * DATA_DEPTH;
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    OUT
  } state_t;
  localparam logic [DATA_WIDTH-1:0] C1 = 32'h00007D8A;
  localparam logic [DATA_WIDTH-1:0] C2 = 32'h00007642;
  localparam logic [DATA_WIDTH-1:0] C3 = 32'h00006A6E;
  localparam logic [DATA_WIDTH-1:0] C4 = 32'h00005A82;
  localparam logic [DATA_WIDTH-1:0] C5 = 32'h0000471D;
  localparam logic [DATA_WIDTH-1:0] C6 = 32'h000030FC;
  localparam logic [DATA_WIDTH-1:0] C7 = 32'h000018F9;
  localparam logic [DATA_WIDTH-1:0] BASIS [DATA_DEPTH][DATA_DEPTH] = '{
    '{ C4,  C4,  C4,  C4,  C4,  C4,  C4,  C4},
    '{ C1,  C3,  C5,  C7, -C7, -C5, -C3, -C1},
    '{ C2,  C6, -C6, -C2, -C2, -C6,  C6,  C2},
    '{ C3, -C7, -C1, -C5,  C5,  C1,  C7, -C3},
    '{ C4, -C4, -C4,  C4,  C4, -C4, -C4,  C4},
    '{ C5, -C1,  C7,  C3, -C3, -C7,  C1, -C5},
    '{ C6, -C2,  C2, -C6, -C6,  C2, -C2,  C6},
    '{ C7, -C5,  C3, -C1,  C1, -C3,  C5, -C7}
  };
endpackage

// File: rtl/dct_row_sequencer_if.sv
// dct_row_sequencer_if: input row, MAC and output row signals of the sequencer
interface dct_row_sequencer_if;
  import dct_row_sequencer_pkg::*;
  logic                  in_valid;
  logic                  in_ready;
  logic [ROW_WIDTH-1:0]  in_data;
  logic [ROW_WIDTH-1:0]  mac_data;
  logic [ROW_WIDTH-1:0]  mac_coeff;
  logic [DATA_WIDTH-1:0] mac_result;
  logic                  out_valid;
  logic                  out_ready;
  logic [ROW_WIDTH-1:0]  out_data;
  logic                  busy;
  modport master (
    input  in_valid, in_data, mac_result, out_ready,
    output in_ready, mac_data, mac_coeff, out_valid, out_data, busy
  );
  modport slave (
    output in_valid, in_data, mac_result, out_ready,
    input  in_ready, mac_data, mac_coeff, out_valid, out_data, busy
  );
endinterface

// File: rtl/dct_row_sequencer_coeff_rom.sv
// dct_row_sequencer_coeff_rom: combinational basis row lookup, element n in slot n
module dct_row_sequencer_coeff_rom
  import dct_row_sequencer_pkg::*;
(
  input  logic [2:0]           k,
  output logic [ROW_WIDTH-1:0] row
);
  for (genvar n = 0; n < DATA_DEPTH; n++) begin : g_col
    assign row[n*DATA_WIDTH +: DATA_WIDTH] = BASIS[k][n];
  end
endmodule

// File: rtl/dct_row_sequencer.sv
// dct_row_sequencer: feeds one row and eight basis rows to the MAC and gathers the 8 coefficients
module dct_row_sequencer
  import dct_row_sequencer_pkg::*;
(
  input logic clk,
  input logic reset,
  dct_row_sequencer_if.master bus
);
  state_t               state, state_nx;
  logic [2:0]           k, cap_idx;
  logic                 cap_en;
  logic [ROW_WIDTH-1:0] row, res, rom_row;
  dct_row_sequencer_coeff_rom u_rom (
    .k  (k),
    .row(rom_row)
  );
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  // next state: one row in, eight issue cycles, one drain cycle, hold until taken
  always_comb begin
    state_nx = (state == IDLE  && bus.in_valid)  ? ISSUE :
               (state == ISSUE && k == 3'd7)     ? DRAIN :
               (state == DRAIN)                  ? OUT   :
               (state == OUT   && bus.out_ready) ? IDLE  : state;
  end
  // outputs decoded from state; coefficients only reach the MAC while issuing
  always_comb begin
    bus.in_ready  = state == IDLE;
    bus.busy      = state != IDLE;
    bus.out_valid = state == OUT;
    bus.out_data  = res;
    bus.mac_data  = row;
    bus.mac_coeff = (state == ISSUE) ? rom_row : '0;
  end
  // row latch, basis index and result capture one cycle behind the issue index
  always_ff @(posedge clk) begin
    if (reset) begin
      k       <= '0;
      cap_en  <= 1'b0;
      cap_idx <= '0;
      row     <= '0;
      res     <= '0;
    end else begin
      k       <= (state == ISSUE) ? k + 3'd1 : '0;
      cap_en  <= state == ISSUE;
      cap_idx <= k;
      if (state == IDLE && bus.in_valid) row <= bus.in_data;
      if (cap_en) res[cap_idx*DATA_WIDTH +: DATA_WIDTH] <= bus.mac_result;
    end
  end
endmodule
